// File: rtl/afe_ro_sram_reader.sv
`timescale 1ns / 1ps
// afe_ro_sram_reader
//
// Read-side drain engine for the AFE readout sample SRAM. A start pulse latches a window
// (base address, word count). The block then issues single-port SRAM reads with one-cycle
// read latency, absorbs that latency in a small prefetch FIFO, and presents the samples on
// a valid/ready stream. last_o marks the final word of the window.
//
// Optional feature: define AFE_RO_READER_STALL_CNT_EN to enable the saturating backpressure
// counter on stall_cnt_o. When the macro is undefined, stall_cnt_o is tied to zero.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i, abort_i        request pulse (ignored while busy), transfer cancel
//   base_addr_i, len_i      window base and word count (0..2^ADDR_WIDTH), sampled on start
//   busy_o, done_o          transfer in progress, one-cycle completion pulse
//   sram_cen_o/wen_o/addr_o SRAM read port (active-low enables, wen constant high)
//   sram_rdata_i            SRAM read data, valid the cycle after a read is issued
//   data_o/valid_o/ready_i  output stream; last_o qualifies the final word
//   stall_cnt_o             cycles with valid_o=1 and ready_i=0 since the last start
module afe_ro_sram_reader #(
  parameter int unsigned AFE_DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [ADDR_WIDTH-1:0]     base_addr_i,
  input  logic [ADDR_WIDTH:0]       len_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      sram_cen_o,
  output logic                      sram_wen_o,
  output logic [ADDR_WIDTH-1:0]     sram_addr_o,
  input  logic [AFE_DATA_WIDTH-1:0] sram_rdata_i,
  output logic [AFE_DATA_WIDTH-1:0] data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      last_o,
  output logic [31:0]               stall_cnt_o
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CntW:0]       DepthOcc = (CntW + 1)'(FIFO_DEPTH);
  localparam logic [CntW-1:0]     DepthCnt = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0]     CntOne   = CntW'(1);
  localparam logic [PtrW-1:0]     PtrOne   = PtrW'(1);
  localparam logic [PtrW-1:0]     PtrLast  = PtrW'(FIFO_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   LenOne  = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]     sram_addr_q, sram_addr_d;
  logic [ADDR_WIDTH:0]       issue_cnt_q, issue_cnt_d;
  logic [ADDR_WIDTH:0]       pop_cnt_q, pop_cnt_d;
  logic                      inflight_q, inflight_d;
  logic [PtrW-1:0]           wptr_q, wptr_d;
  logic [PtrW-1:0]           rptr_q, rptr_d;
  logic [CntW-1:0]           fifo_cnt_q, fifo_cnt_d;
  logic [AFE_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [CntW:0] occ;
  logic          fifo_empty;
  logic          run_ok;
  logic          issue;
  logic          push;
  logic          pop;
  logic          start_acc;

  always_comb begin
    // Occupancy counts the read in flight so the FIFO can never be overrun by its data.
    occ        = {1'b0, fifo_cnt_q} + {{CntW{1'b0}}, inflight_q};
    fifo_empty = (fifo_cnt_q == '0);
    run_ok     = (state_q == StRun) && !abort_i;
    issue      = run_ok && (issue_cnt_q != '0) && (occ < DepthOcc);
    push       = run_ok && inflight_q;
    pop        = run_ok && !fifo_empty && ready_i;
    start_acc  = (state_q == StIdle) && start_i && !abort_i;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    sram_addr_d = sram_addr_q;
    issue_cnt_d = issue_cnt_q;
    pop_cnt_d   = pop_cnt_q;
    inflight_d  = inflight_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    fifo_cnt_d  = fifo_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start_acc) begin
          if (len_i != '0) begin
            addr_d      = base_addr_i;
            issue_cnt_d = len_i;
            pop_cnt_d   = len_i;
            state_d     = StRun;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        if (abort_i) begin
          // Flush and drop the pending read; its data is never captured.
          inflight_d  = 1'b0;
          wptr_d      = '0;
          rptr_d      = '0;
          fifo_cnt_d  = '0;
          issue_cnt_d = '0;
          pop_cnt_d   = '0;
          state_d     = StIdle;
        end else begin
          inflight_d = issue;
          if (issue) begin
            sram_addr_d = addr_q;
            addr_d      = addr_q + AddrOne;
            issue_cnt_d = issue_cnt_q - LenOne;
          end
          if (push) begin
            wptr_d = (wptr_q == PtrLast) ? '0 : wptr_q + PtrOne;
          end
          if (pop) begin
            rptr_d    = (rptr_q == PtrLast) ? '0 : rptr_q + PtrOne;
            pop_cnt_d = pop_cnt_q - LenOne;
            if (pop_cnt_q == LenOne) begin
              state_d = StDone;
            end
          end
          if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + CntOne;
          end else if (pop && !push) begin
            fifo_cnt_d = fifo_cnt_q - CntOne;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      sram_addr_q <= '0;
      issue_cnt_q <= '0;
      pop_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      sram_addr_q <= sram_addr_d;
      issue_cnt_q <= issue_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      inflight_q  <= inflight_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

  // Storage needs no reset: the count gates every read of it.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= sram_rdata_i;
    end
  end

  assign busy_o      = (state_q == StRun);
  assign done_o      = (state_q == StDone);
  assign sram_cen_o  = !issue;
  assign sram_wen_o  = 1'b1;
  assign sram_addr_o = issue ? addr_q : sram_addr_q;
  assign valid_o     = !fifo_empty;
  assign data_o      = fifo_empty ? '0 : mem_q[rptr_q];
  assign last_o      = !fifo_empty && (pop_cnt_q == LenOne);

`ifdef AFE_RO_READER_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (start_acc) begin
      stall_cnt_d = '0;
    end else if (valid_o && !ready_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

`ifndef SYNTHESIS
  // Issue throttling must make overflow impossible.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push && !pop) begin
      assert (fifo_cnt_q < DepthCnt);
    end
  end
`endif

endmodule

// File: tb/tb_afe_ro_sram_reader.sv
`timescale 1ns / 1ps
module tb_afe_ro_sram_reader;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NWORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   len = '0;
  logic          busy, done, cen, wen, valid, last;
  logic          ready = 1'b1;
  logic [AW-1:0] addr;
  logic [DW-1:0] rdata = '0;
  logic [DW-1:0] data;
  logic [31:0]   stall_cnt;

  always #5 clk = ~clk;

  afe_ro_sram_reader #(
    .AFE_DATA_WIDTH(DW),
    .ADDR_WIDTH    (AW),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .abort_i     (abort),
    .base_addr_i (base),
    .len_i       (len),
    .busy_o      (busy),
    .done_o      (done),
    .sram_cen_o  (cen),
    .sram_wen_o  (wen),
    .sram_addr_o (addr),
    .sram_rdata_i(rdata),
    .data_o      (data),
    .valid_o     (valid),
    .ready_i     (ready),
    .last_o      (last),
    .stall_cnt_o (stall_cnt)
  );

  // SRAM model: one-cycle read latency, garbage on cycles without a read.
  logic [DW-1:0] mem [NWORDS];
  always @(posedge clk) rdata <= !cen ? mem[addr] : DW'($urandom);

  // Sink readiness: 0 = always ready, 1 = random, 2 = pattern 1,0,0 repeating.
  int ready_mode = 0;
  int pat = 0;
  always @(posedge clk) begin
    #1;
    pat++;
    case (ready_mode)
      0:       ready = 1'b1;
      1:       ready = 1'($urandom_range(0, 1));
      default: ready = (pat % 3 == 0);
    endcase
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: queues of the addresses that must be read and the words
  // that must come out, in order, plus the words still owed to the sink.
  logic [AW-1:0] q_addr[$];
  logic [DW-1:0] q_data[$];
  bit            busy_m = 0, done_m = 0, busy_n, done_n;
  int            remaining = 0, outstanding = 0, stall_m = 0;
  int            cyc = 0;
  int            xfer_start_cyc = 0, first_valid_cyc = -1, last_hs_cyc = 0, done_cyc = 0;
  int            xfer_hs = 0, xfer_cen = 0, last_cnt = 0, done_cnt = 0;
  logic [DW-1:0] last_data = '0;
  logic [DW-1:0] xfer_data [16];
  logic [AW-1:0] xfer_addr [16];

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q_addr.delete();
      q_data.delete();
      busy_m = 0;
      done_m = 0;
      remaining = 0;
      outstanding = 0;
      stall_m = 0;
    end else begin
      chk("busy", busy, busy_m);
      chk("done", done, done_m);
      chk("wen", wen, 1);
`ifdef AFE_RO_READER_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, stall_m);
`else
      chk("stall_cnt", stall_cnt, 0);
`endif
      if (!busy_m) begin
        chk("cen_idle", cen, 1);
        chk("valid_idle", valid, 0);
      end
      chk("last", last, valid && (remaining == 1));
      if (valid && busy_m) begin
        chk("words_left", q_data.size() != 0, 1);
        if (q_data.size() != 0) chk("data", data, q_data[0]);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end

      busy_n = busy_m;
      done_n = 0;
      if (busy_m) begin
        if (!cen) begin
          chk("occupancy", outstanding < DEPTH, 1);
          chk("reads_left", q_addr.size() != 0, 1);
          if (q_addr.size() != 0) chk("sram_addr", addr, q_addr.pop_front());
          if (xfer_cen < 16) xfer_addr[xfer_cen] = addr;
          xfer_cen++;
          outstanding++;
        end
        if (valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (valid && ready && q_data.size() != 0) begin
          if (xfer_hs < 16) xfer_data[xfer_hs] = data;
          if (last) begin
            last_cnt++;
            last_data = data;
          end
          void'(q_data.pop_front());
          xfer_hs++;
          last_hs_cyc = cyc;
          remaining--;
          outstanding--;
          if (remaining == 0) begin
            busy_n = 0;
            done_n = 1;
          end
        end
        if (abort) begin
          busy_n = 0;
          done_n = 0;
          q_addr.delete();
          q_data.delete();
          outstanding = 0;
          remaining = 0;
        end
      end else if (!done_m && start && !abort) begin
        stall_m = 0;
        xfer_start_cyc = cyc;
        first_valid_cyc = -1;
        xfer_hs = 0;
        xfer_cen = 0;
        last_cnt = 0;
        done_cnt = 0;
        outstanding = 0;
        remaining = int'(len);
        for (int i = 0; i < int'(len); i++) begin
          logic [AW-1:0] a;
          a = AW'(int'(base) + i);
          q_addr.push_back(a);
          q_data.push_back(mem[a]);
        end
        if (len == 0) done_n = 1;
        else busy_n = 1;
      end
      if (valid && !ready) stall_m++;
      busy_m = busy_n;
      done_m = done_n;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input int b, input int l);
    base  = AW'(b);
    len   = (AW + 1)'(l);
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy_m || done_m) && n < budget) begin
      cycle();
      n++;
    end
    chk("idle_timeout", busy_m || done_m, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_last"}, last, 0);
    chk({tag, "_cen"}, cen, 1);
    chk({tag, "_wen"}, wen, 1);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_stall"}, stall_cnt, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < int'(NWORDS); i++) mem[i] = DW'(32'hA000 + i);
    repeat (2) cycle();
    check_reset_outputs("reset");
    rst = 1'b0;
    cycle();

    // Basic window at full rate.
    ready_mode = 0;
    start_xfer(16, 8);
    wait_idle(200);
    chk("basic_latency", first_valid_cyc - xfer_start_cyc, 3);
    chk("basic_back_to_back", last_hs_cyc - first_valid_cyc, 7);
    chk("basic_words", xfer_hs, 8);
    chk("basic_first", xfer_data[0], 32'hA010);
    chk("basic_word7", xfer_data[7], 32'hA017);
    chk("basic_last_cnt", last_cnt, 1);
    chk("basic_last_data", last_data, 32'hA017);
    chk("basic_reads", xfer_cen, 8);
    chk("basic_done_cnt", done_cnt, 1);

    // Address wrap.
    start_xfer(1022, 4);
    wait_idle(200);
    chk("wrap_a0", xfer_addr[0], 1022);
    chk("wrap_a1", xfer_addr[1], 1023);
    chk("wrap_a2", xfer_addr[2], 0);
    chk("wrap_a3", xfer_addr[3], 1);
    chk("wrap_d2", xfer_data[2], 32'hA000);

    // Backpressure.
    ready_mode = 2;
    start_xfer(40, 6);
    wait_idle(400);
    chk("bp_words", xfer_hs, 6);
    chk("bp_last_data", last_data, 32'hA02D);
    chk("bp_stalled", stall_m > 0, 1);
    ready_mode = 0;
    cycle();

    // Zero length.
    start_xfer(5, 0);
    wait_idle(20);
    chk("zero_done_cnt", done_cnt, 1);
    chk("zero_done_delay", done_cyc - xfer_start_cyc, 1);
    chk("zero_reads", xfer_cen, 0);

    // Start while busy is ignored.
    start_xfer(100, 32);
    repeat (4) cycle();
    start_xfer(500, 3);
    wait_idle(400);
    chk("ign_words", xfer_hs, 32);
    chk("ign_reads", xfer_cen, 32);
    chk("ign_done_cnt", done_cnt, 1);
    chk("ign_first", xfer_data[0], 32'hA064);
    chk("ign_word15", xfer_data[15], 32'hA073);

    // Abort while the 5th word is presented.
    start_xfer(200, 64);
    for (int n = 0; n < 100 && xfer_hs != 4; n++) cycle();
    chk("abort_reach", xfer_hs, 4);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("abort_valid", valid, 0);
    chk("abort_cen", cen, 1);
    chk("abort_busy", busy, 0);
    chk("abort_word4", xfer_data[4], 32'hA0CC);
    repeat (5) cycle();
    chk("abort_no_done", done_cnt, 0);
    start_xfer(0, 2);
    wait_idle(100);
    chk("post_abort_words", xfer_hs, 2);
    chk("post_abort_d0", xfer_data[0], 32'hA000);
    chk("post_abort_d1", xfer_data[1], 32'hA001);
    chk("post_abort_done", done_cnt, 1);

    // Abort and start together in idle: abort wins.
    abort = 1'b1;
    start_xfer(10, 5);
    abort = 1'b0;
    repeat (3) cycle();
    chk("abort_start_busy", busy, 0);

    // Reset mid-run.
    start_xfer(300, 64);
    repeat (10) cycle();
    rst = 1'b1;
    cycle();
    check_reset_outputs("midrst");
    rst = 1'b0;
    repeat (3) cycle();
    chk("midrst_no_done", done_cnt, 0);
    start_xfer(0, 2);
    wait_idle(100);
    chk("post_rst_words", xfer_hs, 2);
    chk("post_rst_d1", xfer_data[1], 32'hA001);

    // Randomized windows, sink behaviour and aborts against the reference.
    for (int i = 0; i < int'(NWORDS); i++) mem[i] = $urandom;
    for (int t = 0; t < 24; t++) begin
      int l;
      l = (t == 3) ? 1024 : (t == 9) ? 0 : int'($urandom_range(1, 40));
      ready_mode = int'($urandom_range(0, 2));
      start_xfer(int'($urandom_range(0, NWORDS - 1)), l);
      if (t % 5 == 2) begin
        repeat ($urandom_range(0, 30)) cycle();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
      end
      wait_idle(8000);
    end
    ready_mode = 0;
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
